// File: rtl/gf8_reduce_acc.sv
// rtl/gf8_reduce_acc.sv - GF(2^8) reduction of a carry-less product with per-frame XOR accumulation
module gf8_reduce_acc #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_prod,
  input  logic        in_first,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [7:0]  out_count
);

  logic        r_val;
  logic [7:0]  r_data;
  logic        r_first;
  logic        r_last;
  logic [7:0]  acc;
  logic [7:0]  cnt;

  logic [14:0] red_v;
  logic        r_adv;
  logic        in_fire;
  logic [7:0]  sum;
  logic [7:0]  cnt_base;
  logic [7:0]  cnt_next;

  always_comb begin
    red_v = in_prod;
    for (int k = 14; k >= 8; k--) begin
      if (red_v[k]) begin
        red_v = red_v ^ (15'(POLY) << (k - 8));
      end
    end
  end

  // A last beat must not overwrite a result the consumer has not taken yet.
  assign r_adv    = r_val && !(r_last && out_valid && !out_ready);
  assign in_ready = !rst && (!r_val || r_adv);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    sum      = (r_first ? 8'h00 : acc) ^ r_data;
    cnt_base = r_first ? 8'h00 : cnt;
    cnt_next = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val   <= 1'b0;
      r_data  <= 8'h00;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (in_fire) begin
      r_val   <= 1'b1;
      r_data  <= red_v[7:0];
      r_first <= in_first;
      r_last  <= in_last;
    end else if (r_adv) begin
      r_val   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= 8'h00;
      cnt       <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_count <= 8'h00;
    end else if (r_adv && r_last) begin
      out_data  <= sum;
      out_count <= cnt_next;
      out_valid <= 1'b1;
      acc       <= 8'h00;
      cnt       <= 8'h00;
    end else begin
      if (r_adv) begin
        acc <= sum;
        cnt <= cnt_next;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gf8_reduce_acc.sv
// tb/tb_gf8_reduce_acc.sv - directed bench for gf8_reduce_acc with a frame-level reference model
module tb_gf8_reduce_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_prod = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [7:0]  out_count;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  gf8_reduce_acc #(.POLY(9'h11B)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Product mod x^8+x^4+x^3+x+1 as a sum of precomputed powers x^k mod p.
  function automatic logic [7:0] mred(input logic [14:0] p);
    logic [7:0] t;
    logic [7:0] r;
    t = 8'h01;
    r = 8'h00;
    for (int k = 0; k < 15; k++) begin
      if (p[k]) r = r ^ t;
      t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
    end
    return r;
  endfunction

  logic [7:0] exp_d[$];
  logic [7:0] exp_c[$];
  logic [7:0] got_d[$];
  logic [7:0] got_c[$];
  logic [7:0] macc = 8'h00;
  int         mcnt = 0;
  bit         hold = 1'b0;
  logic [7:0] hd, hc;

  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", int'(in_ready), 0);
      macc = 8'h00;
      mcnt = 0;
      exp_d.delete();
      exp_c.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(hd));
        chk("hold_count", int'(out_count), int'(hc));
      end
      if (out_valid && exp_d.size() == 0) begin
        chk("spurious_out_valid", int'(out_valid), 0);
      end else if (out_valid && out_ready) begin
        chk("out_data", int'(out_data), int'(exp_d[0]));
        chk("out_count", int'(out_count), int'(exp_c[0]));
        got_d.push_back(out_data);
        got_c.push_back(out_count);
        void'(exp_d.pop_front());
        void'(exp_c.pop_front());
      end
      hold = out_valid && !out_ready;
      hd = out_data;
      hc = out_count;
      if (in_valid && in_ready) begin
        if (in_first) begin
          macc = 8'h00;
          mcnt = 0;
        end
        macc = macc ^ mred(in_prod);
        if (mcnt < 255) mcnt++;
        if (in_last) begin
          exp_d.push_back(macc);
          exp_c.push_back(8'(mcnt));
          macc = 8'h00;
          mcnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [14:0] p, input logic f, input logic l);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_prod = p;
    in_first = f;
    in_last = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        chk("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_d.size() != 0 || out_valid) && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("drain_timeout", int'(waited >= 100), 0);
  endtask

  initial begin
    int base;
    int c0;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int c0;

    chk("model_2b79", int'(mred(15'h2B79)), 8'hC1);
    chk("model_0589", int'(mred(15'h0589)), 8'hFE);
    chk("model_0100", int'(mred(15'h0100)), 8'h1B);
    chk("model_7fff", int'(mred(15'h7FFF)), 8'h1A);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_count", int'(out_count), 0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(15'h2B79, 1'b1, 1'b1);
    @(negedge clk);
    chk("latency_not_yet", int'(out_valid), 0);
    @(negedge clk);
    chk("latency_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 8'hC1);
    chk("single_count", int'(out_count), 1);
    @(posedge clk);
    #1;
    drain();

    send(15'h2B79, 1'b1, 1'b0);
    send(15'h0589, 1'b0, 1'b1);
    drain();
    chk("two_beat_data", int'(got_d[got_d.size()-1]), 8'h3F);
    chk("two_beat_count", int'(got_c[got_c.size()-1]), 2);

    out_ready = 1'b0;
    send(15'h0100, 1'b1, 1'b1);
    send(15'h0001, 1'b1, 1'b0);
    send(15'h0002, 1'b0, 1'b0);
    send(15'h0004, 1'b0, 1'b0);
    send(15'h0008, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_data", int'(out_data), 8'h1B);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_valid", int'(out_valid), 1);
    chk("bp_first_data", int'(out_data), 8'h1B);
    @(negedge clk);
    chk("bp_second_valid", int'(out_valid), 1);
    chk("bp_second_data", int'(out_data), 8'h0F);
    chk("bp_second_count", int'(out_count), 4);
    @(posedge clk);
    #1;
    drain();

    base = got_d.size();
    c0 = cyc;
    send(15'h0000, 1'b1, 1'b1);
    send(15'h00FF, 1'b1, 1'b1);
    send(15'h0100, 1'b1, 1'b1);
    send(15'h7FFF, 1'b1, 1'b1);
    chk("b2b_cycles", cyc - c0, 4);
    drain();
    chk("b2b_results", got_d.size() - base, 4);
    chk("corner_0000", int'(got_d[base]), 8'h00);
    chk("corner_00ff", int'(got_d[base+1]), 8'hFF);
    chk("corner_0100", int'(got_d[base+2]), 8'h1B);
    chk("corner_7fff", int'(got_d[base+3]), 8'h1A);

    for (int i = 0; i < 300; i++) begin
      send(15'h0001, i == 0, i == 299);
    end
    drain();
    chk("sat_data", int'(got_d[got_d.size()-1]), 8'h00);
    chk("sat_count", int'(got_c[got_c.size()-1]), 255);

    base = got_d.size();
    send(15'h0001, 1'b1, 1'b0);
    send(15'h0002, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_output", got_d.size() - base, 0);
    send(15'h0100, 1'b1, 1'b1);
    drain();
    chk("rst_results", got_d.size() - base, 1);
    chk("rst_after_data", int'(got_d[got_d.size()-1]), 8'h1B);
    chk("rst_after_count", int'(got_c[got_c.size()-1]), 1);

    send(15'h0003, 1'b1, 1'b0);
    send(15'h0005, 1'b1, 1'b1);
    drain();
    chk("midfirst_data", int'(got_d[got_d.size()-1]), 8'h05);
    chk("midfirst_count", int'(got_c[got_c.size()-1]), 1);

    send(15'h0003, 1'b0, 1'b1);
    drain();
    chk("nofirst_data", int'(got_d[got_d.size()-1]), 8'h03);
    chk("nofirst_count", int'(got_c[got_c.size()-1]), 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
